// File: rtl/sha256_stream_core.sv
// Iterative SHA-256 compression core: word-indexed block load, H chaining, serial digest readout.
// Optional SHA-224 mode is compiled in with the SHA224_EN macro.
module sha256_stream_core #(
    parameter int OUT_WIDTH = 8,
    parameter int IDX_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 msg_dv_in,
    input  logic [IDX_WIDTH-1:0] msg_idx_in,
    input  logic [31:0]          msg_word_in,
    input  logic                 blk_first_in,
    input  logic                 blk_last_in,
    input  logic                 mode_224_in,
    output logic                 load_ready_out,
    output logic                 busy_out,
    output logic [OUT_WIDTH-1:0] hash_out,
    output logic                 hash_dv_out,
    input  logic                 hash_rdy_in
);

    if (!(OUT_WIDTH == 8 || OUT_WIDTH == 16 || OUT_WIDTH == 32)) begin : g_bad_out_width
        $error("sha256_stream_core: OUT_WIDTH must be 8, 16 or 32");
    end
    if (IDX_WIDTH < 4) begin : g_bad_idx_width
        $error("sha256_stream_core: IDX_WIDTH must be at least 4");
    end

    typedef enum logic [1:0] {LOAD, COMP, UPD, OUT} state_t;

    localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    localparam logic [5:0]   LAST256 = 6'(256 / OUT_WIDTH - 1);
    localparam logic [5:0]   LAST224 = 6'(224 / OUT_WIDTH - 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t       state;
    logic [255:0] h_reg;
    logic [31:0]  va, vb, vc, vd, ve, vf, vg, vh;
    logic [5:0]   rnd;
    logic [5:0]   beat;
    logic         last_q;
    logic [31:0]  msg_buf [16];
    logic [31:0]  win [16];

    logic         idx_ok;
    logic [3:0]   idx4;
    logic         accept15;
    logic [31:0]  t1, t2, w_new;
    logic [255:0] h_sum;
    logic [255:0] iv_sel;
    logic [5:0]   last_beat;

    assign idx_ok   = 32'(msg_idx_in) < 32'd16;
    assign idx4     = msg_idx_in[3:0];
    assign accept15 = (state == LOAD) && msg_dv_in && idx_ok && (idx4 == 4'd15);

    assign t1 = vh + big_s1(ve) + ((ve & vf) ^ (~ve & vg)) + K[rnd] + win[0];
    assign t2 = big_s0(va) + ((va & vb) ^ (va & vc) ^ (vb & vc));
    assign w_new = small_s1(win[14]) + win[9] + small_s0(win[1]) + win[0];

    assign h_sum = {h_reg[255:224] + va, h_reg[223:192] + vb, h_reg[191:160] + vc, h_reg[159:128] + vd,
                    h_reg[127:96]  + ve, h_reg[95:64]   + vf, h_reg[63:32]   + vg, h_reg[31:0]    + vh};

`ifdef SHA224_EN
    logic m224;
    assign iv_sel    = mode_224_in ? IV224 : IV256;
    assign last_beat = m224 ? LAST224 : LAST256;
`else
    logic unused_mode;
    assign unused_mode = mode_224_in;
    assign iv_sel      = IV256;
    assign last_beat   = LAST256;
`endif

    // Message buffer keeps its words across blocks; the schedule window is a separate copy
    // so rolling it during COMP never disturbs the buffer.
    always_ff @(posedge clk) begin
        if (state == LOAD && msg_dv_in && idx_ok) begin
            msg_buf[idx4] <= msg_word_in;
        end
        if (accept15) begin
            for (int i = 0; i < 15; i++) win[i] <= msg_buf[i];
            win[15] <= msg_word_in;
        end else if (state == COMP) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
            win[15] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LOAD;
            h_reg          <= IV256;
            {va, vb, vc, vd, ve, vf, vg, vh} <= '0;
            rnd            <= '0;
            beat           <= '0;
            last_q         <= 1'b0;
            load_ready_out <= 1'b1;
            busy_out       <= 1'b0;
            hash_dv_out    <= 1'b0;
            hash_out       <= '0;
`ifdef SHA224_EN
            m224           <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (accept15) begin
                        state          <= COMP;
                        last_q         <= blk_last_in;
                        rnd            <= '0;
                        load_ready_out <= 1'b0;
                        busy_out       <= 1'b1;
                        if (blk_first_in) begin
                            h_reg <= iv_sel;
                            {va, vb, vc, vd, ve, vf, vg, vh} <= iv_sel;
`ifdef SHA224_EN
                            m224  <= mode_224_in;
`endif
                        end else begin
                            {va, vb, vc, vd, ve, vf, vg, vh} <= h_reg;
                        end
                    end
                end
                COMP: begin
                    va  <= t1 + t2;
                    vb  <= va;
                    vc  <= vb;
                    vd  <= vc;
                    ve  <= vd + t1;
                    vf  <= ve;
                    vg  <= vf;
                    vh  <= vg;
                    rnd <= rnd + 6'd1;
                    if (rnd == 6'd63) state <= UPD;
                end
                UPD: begin
                    h_reg <= h_sum;
                    if (last_q) begin
                        state       <= OUT;
                        beat        <= '0;
                        hash_dv_out <= 1'b1;
                        hash_out    <= h_sum[255 -: OUT_WIDTH];
                    end else begin
                        state          <= LOAD;
                        load_ready_out <= 1'b1;
                        busy_out       <= 1'b0;
                    end
                end
                OUT: begin
                    // H is shifted out beat by beat and restored to the IV once drained.
                    if (hash_rdy_in) begin
                        if (beat == last_beat) begin
                            state          <= LOAD;
                            h_reg          <= IV256;
                            hash_dv_out    <= 1'b0;
                            hash_out       <= '0;
                            load_ready_out <= 1'b1;
                            busy_out       <= 1'b0;
                        end else begin
                            beat     <= beat + 6'd1;
                            h_reg    <= h_reg << OUT_WIDTH;
                            hash_out <= h_reg[255 - OUT_WIDTH -: OUT_WIDTH];
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench for sha256_stream_core: known-answer digests, latency, backpressure and reset.
// Expected digest beats are queued as each final block is sent and popped as the core emits them.
module tb_sha256_stream_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_dv_in;
    logic [4:0]  msg_idx_in;
    logic [31:0] msg_word_in;
    logic        blk_first_in;
    logic        blk_last_in;
    logic        mode_224_in;
    logic        load_ready_out;
    logic        busy_out;
    logic [7:0]  hash_out;
    logic        hash_dv_out;
    logic        hash_rdy_in;

    sha256_stream_core #(.OUT_WIDTH(8), .IDX_WIDTH(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .msg_dv_in      (msg_dv_in),
        .msg_idx_in     (msg_idx_in),
        .msg_word_in    (msg_word_in),
        .blk_first_in   (blk_first_in),
        .blk_last_in    (blk_last_in),
        .mode_224_in    (mode_224_in),
        .load_ready_out (load_ready_out),
        .busy_out       (busy_out),
        .hash_out       (hash_out),
        .hash_dv_out    (hash_dv_out),
        .hash_rdy_in    (hash_rdy_in)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_2BLK  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_224   = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

    int          ntests = 0;
    int          nfail  = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] blk [16];
    int          k;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_digest(input logic [255:0] d, input int nbeats);
        for (int i = 0; i < nbeats; i++) exp_q.push_back(d[255 - 8*i -: 8]);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    endtask

    task automatic load_abc();
        clear_blk();
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input logic first,
                             input logic last, input logic m224);
        msg_dv_in    = 1'b1;
        msg_idx_in   = 5'(idx);
        msg_word_in  = w;
        blk_first_in = first;
        blk_last_in  = last;
        mode_224_in  = m224;
        @(negedge clk);
        msg_dv_in    = 1'b0;
        blk_first_in = 1'b0;
        blk_last_in  = 1'b0;
        mode_224_in  = 1'b0;
    endtask

    // Words 0..14 go in reverse order; index 15 always last since it starts the block.
    task automatic send_block(input logic first, input logic last, input logic m224, input logic inject);
        for (int i = 14; i >= 0; i--) send_word(i, blk[i], first, last, m224);
        if (inject) begin
            send_word(20, 32'hdeadbeef, first, last, m224);
            send_word(31, 32'hcafef00d, first, last, m224);
            chk("ready_after_bad_idx", load_ready_out, 1);
        end
        send_word(15, blk[15], first, last, m224);
    endtask

    // Returns k = number of sample points after the index-15 edge until dv (last) or ready rises.
    task automatic measure(input logic last, input logic noise, output int kk);
        kk = 1;
        chk("ready_low_after_idx15", load_ready_out, 0);
        chk("busy_after_idx15", busy_out, 1);
        while (kk < 300 && !(last ? hash_dv_out : load_ready_out)) begin
            if (noise && kk < 10) begin
                msg_dv_in    = 1'b1;
                msg_idx_in   = 5'd15;
                msg_word_in  = $urandom;
                blk_first_in = 1'b1;
            end else begin
                msg_dv_in    = 1'b0;
                blk_first_in = 1'b0;
            end
            @(negedge clk);
            kk++;
        end
        msg_dv_in    = 1'b0;
        blk_first_in = 1'b0;
    endtask

    task automatic collect(input int stall_beat, input int stall_len);
        int         got = 0;
        int         stalled = 0;
        int         cyc = 0;
        logic [7:0] e;
        while (exp_q.size() > 0 && cyc < 1000) begin
            if (hash_dv_out) begin
                if (got == stall_beat && stalled < stall_len) begin
                    hash_rdy_in = 1'b0;
                    stalled++;
                    chk("hold_beat", hash_out, exp_q[0]);
                end else begin
                    hash_rdy_in = 1'b1;
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", got), hash_out, e);
                    got++;
                end
            end else begin
                hash_rdy_in = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        hash_rdy_in = 1'b0;
        chk("beats_left", exp_q.size(), 0);
        exp_q.delete();
        chk("dv_after_last", hash_dv_out, 0);
        chk("out_after_last", hash_out, 0);
        chk("ready_after_last", load_ready_out, 1);
        chk("busy_after_last", busy_out, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        msg_dv_in    = 1'b0;
        msg_idx_in   = '0;
        msg_word_in  = '0;
        blk_first_in = 1'b0;
        blk_last_in  = 1'b0;
        mode_224_in  = 1'b0;
        hash_rdy_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", load_ready_out, 1);
        chk("rst_busy", busy_out, 0);
        chk("rst_dv", hash_dv_out, 0);
        chk("rst_out", hash_out, 0);

        // "abc", with garbage words driven while the core is compressing
        load_abc();
        push_digest(D_ABC, 32);
        send_block(1'b1, 1'b1, 1'b0, 1'b0);
        measure(1'b1, 1'b1, k);
        chk("abc_latency", k, 66);
        chk("abc_first_beat", hash_out, 8'hba);
        collect(-1, 0);

        // empty message
        clear_blk();
        blk[0] = 32'h80000000;
        push_digest(D_EMPTY, 32);
        send_block(1'b1, 1'b1, 1'b0, 1'b0);
        measure(1'b1, 1'b0, k);
        chk("empty_latency", k, 66);
        collect(-1, 0);

        // two-block 448-bit message
        blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566; blk[3]  = 32'h64656667;
        blk[4]  = 32'h65666768; blk[5]  = 32'h66676869; blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b;
        blk[8]  = 32'h696a6b6c; blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
        blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000; blk[15] = 32'h00000000;
        send_block(1'b1, 1'b0, 1'b0, 1'b0);
        measure(1'b0, 1'b0, k);
        chk("blk1_ready_low_cycles", k - 1, 65);
        chk("blk1_no_dv", hash_dv_out, 0);
        clear_blk();
        blk[15] = 32'h000001c0;
        push_digest(D_2BLK, 32);
        send_block(1'b0, 1'b1, 1'b0, 1'b0);
        measure(1'b1, 1'b0, k);
        chk("blk2_latency", k, 66);
        collect(-1, 0);

        // backpressure: stall 5 cycles on the 8'h5d beat of "abc"
        load_abc();
        push_digest(D_ABC, 32);
        send_block(1'b1, 1'b1, 1'b0, 1'b0);
        measure(1'b1, 1'b0, k);
        collect(12, 5);

        // reset during compression, then "abc" again with out-of-range indices mixed in
        load_abc();
        send_block(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midcomp_rst_ready", load_ready_out, 1);
        chk("midcomp_rst_busy", busy_out, 0);
        chk("midcomp_rst_dv", hash_dv_out, 0);
        push_digest(D_ABC, 32);
        send_block(1'b1, 1'b1, 1'b0, 1'b1);
        measure(1'b1, 1'b0, k);
        chk("after_rst_latency", k, 66);
        collect(-1, 0);

`ifdef SHA224_EN
        load_abc();
        push_digest(D_224, 28);
        send_block(1'b1, 1'b1, 1'b1, 1'b0);
        measure(1'b1, 1'b0, k);
        chk("sha224_latency", k, 66);
        collect(-1, 0);

        load_abc();
        push_digest(D_ABC, 32);
        send_block(1'b1, 1'b1, 1'b0, 1'b0);
        measure(1'b1, 1'b0, k);
        collect(-1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
